alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Registered, parametrised successor of the 8-bit combinational ALU. Accepts one op per
//  valid/ready handshake and returns a registered result plus flags under back-pressure.
//  Adds shifts, xor, compare flags and a multi-cycle shift-add multiply.
//  Sits between the operand/opcode source and the register writeback.
// PARAMETERS
//  WIDTH   8   operand/result width, >= 4
//  MUL_EN  1   1: opcode 1100 runs the multiply FSM; 0: 1100 is an illegal opcode
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      request valid; op accepted on the clk edge when en && ready
//  ready      out  1      block can accept a request this cycle
//  opcode     in   4      1111 add, 1110 sub, 0111 and, 0110 or, 0100 not a, 0101 xor,
//                         1000 shl a by b, 1001 shr (logical) a by b, 1100 mul; others illegal
//  a, b       in   WIDTH  operands, sampled only on acceptance
//  out        out  WIDTH  result (low half for mul)
//  out_hi     out  WIDTH  high half of the mul product; 0 for all other ops
//  cout       out  1      add: carry out; sub: carry of a+~b+1 (1 = no borrow); shl: last bit out; else 0
//  ovf        out  1      signed overflow for add/sub; else 0
//  zero       out  1      out == 0 (mul: {out_hi,out} == 0)
//  neg        out  1      out[WIDTH-1]
//  err        out  1      illegal opcode; out/out_hi = 0, flags 0 except zero = 1
//  out_valid  out  1      result/flags valid; held stable until out_valid && out_ready
//  out_ready  in   1      consumer takes result this cycle
// BEHAVIOUR
//  - Reset (async, any state): FSM -> IDLE; out, out_hi, all flags, out_valid = 0; partial mul discarded.
//  - States: IDLE (no result), EXEC (mul iterating), HOLD (out_valid = 1).
//  - ready = (IDLE) || (HOLD && out_ready). Always 0 in EXEC.
//  - Single-cycle ops: accepted at edge N -> out_valid = 1 after edge N (latency 1); state HOLD.
//  - mul: accepted at edge N -> EXEC for WIDTH cycles (one bit of b per cycle, LSB first,
//    2*WIDTH-bit accumulator) -> HOLD, out_valid = 1 after edge N+WIDTH. Unsigned product.
//  - Shift amount = b modulo WIDTH (low clog2(WIDTH) bits); amount 0 -> out = a, cout = 0.
//  - HOLD && out_ready && en: result retires and the new op is accepted on the same edge
//    (back-to-back, 1 result/cycle for single-cycle ops). HOLD && out_ready && !en -> IDLE.
//  - HOLD && !out_ready: out, out_hi, flags, out_valid held unchanged; en ignored.
//  - Operands/opcode changing while not accepted have no effect.
//  - Arithmetic is modulo 2^WIDTH; no input saturation; no X on outputs after reset.
// STRUCTURE
//  - Shared package alu_pkg: opcode localparams (OP_ADD..OP_MUL), state encoding,
//    op_is_single(opcode) helper.
//  - One sub-module: alu_comb (WIDTH) - combinational datapath for single-cycle ops,
//    producing result, cout, ovf. alu_seq owns FSM, mul iterator, output/flag registers.
// TESTING (WIDTH = 8 unless noted)
//  - add a=ff b=ff -> out=fe cout=1 ovf=0 neg=1 zero=0, out_valid one edge after accept.
//  - sub a=00 b=01 -> out=ff cout=0 ovf=0 neg=1; sub a=80 b=01 -> out=7f ovf=1;
//    or cc|33 -> ff; and cc&33 -> 00 zero=1; not aa -> 55.
//  - mul a=ff b=ff -> ready=0 for 8 cycles, then out_hi=fe out=01 out_valid=1; MUL_EN=0 -> err=1.
//  - back-pressure: out_ready=0 for 5 cycles with en held -> result stable, ready=0, no second
//    accept; out_ready=1 -> retire and accept next op on same edge; stream 4 adds at 1/cycle.
//  - rst asserted mid-mul (cycle 3 of EXEC) -> all outputs 0 immediately, ready=1 after release;
//    illegal opcode 0011 -> err=1 zero=1 out=0; shl a=81 b=09 -> shift 1: out=02 cout=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the opcode encodings, the control FSM state type and a helper that
// classifies opcodes executed in a single cycle by the combinational datapath.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b1111;
    localparam logic [3:0] OP_SUB = 4'b1110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    function automatic logic op_is_single(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_NOT, OP_XOR, OP_SHL, OP_SHR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the operand source, the ALU and writeback.
// master: drives en, opcode, a, b, out_ready; observes ready and the result.
// slave : the ALU; drives ready, out, out_hi, flags and out_valid.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_hi;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output en, opcode, a, b, out_ready,
        input  ready, out, out_hi, cout, ovf, zero, neg, err, out_valid
    );

    modport slave (
        input  en, opcode, a, b, out_ready,
        output ready, out, out_hi, cout, ovf, zero, neg, err, out_valid
    );
endinterface

// File: rtl/alu_comb.sv
// Combinational datapath for all single-cycle ALU operations.
// Ports: opcode/a/b in; result, cout, ovf out. Opcodes outside the
// single-cycle set produce result 0 with both flags clear.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] amt;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] shl_ext;

    // Shift amount is the low log2(WIDTH) bits of b, i.e. b modulo WIDTH.
    assign amt     = b[SW-1:0];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // The extra top bit catches the last bit shifted out; it stays 0 for amt 0.
    assign shl_ext = {1'b0, a} << amt;

    always_comb begin
        result = '0;
        cout   = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                cout   = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                cout   = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_NOT: result = ~a;
            OP_XOR: result = a ^ b;
            OP_SHL: begin
                result = shl_ext[WIDTH-1:0];
                cout   = shl_ext[WIDTH];
            end
            OP_SHR: result = a >> amt;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready request handshake and held result.
// Ports: clk, rst (async, active high), bus (alu_seq_if slave: request
// en/opcode/a/b with ready; result out/out_hi/cout/ovf/zero/neg/err with
// out_valid/out_ready). Single-cycle ops retire one edge after acceptance;
// multiply iterates WIDTH cycles of shift-add before the result appears.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [WIDTH-1:0]   out_hi_q, out_hi_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               err_q, err_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               ready;
    logic               accept;
    logic               is_mul;
    logic               is_single;
    logic [WIDTH-1:0]   comb_res;
    logic               comb_cout;
    logic               comb_ovf;
    logic [2*WIDTH-1:0] acc_next;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .opcode (bus.opcode),
        .a      (bus.a),
        .b      (bus.b),
        .result (comb_res),
        .cout   (comb_cout),
        .ovf    (comb_ovf)
    );

    assign ready     = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
    assign accept    = bus.en && ready;
    assign is_mul    = MUL_EN && (bus.opcode == OP_MUL);
    assign is_single = op_is_single(bus.opcode);
    // Multiplicand is pre-shifted each step, so the LSB of the multiplier
    // always selects whether to add the current partial product.
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_hi_d    = out_hi_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: ;
            ST_EXEC: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = ST_HOLD;
                    out_valid_d = 1'b1;
                    out_d       = acc_next[WIDTH-1:0];
                    out_hi_d    = acc_next[2*WIDTH-1:WIDTH];
                    cout_d      = 1'b0;
                    ovf_d       = 1'b0;
                    zero_d      = (acc_next == '0);
                    neg_d       = acc_next[WIDTH-1];
                    err_d       = 1'b0;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Launch is shared by IDLE and the retire-and-accept path out of HOLD,
        // so it overrides whatever the state case decided above.
        if (accept) begin
            if (is_mul) begin
                state_d     = ST_EXEC;
                out_valid_d = 1'b0;
                acc_d       = '0;
                mcand_d     = {{WIDTH{1'b0}}, bus.a};
                mplier_d    = bus.b;
                cnt_d       = '0;
            end else begin
                state_d     = ST_HOLD;
                out_valid_d = 1'b1;
                out_hi_d    = '0;
                if (is_single) begin
                    out_d  = comb_res;
                    cout_d = comb_cout;
                    ovf_d  = comb_ovf;
                    zero_d = (comb_res == '0);
                    neg_d  = comb_res[WIDTH-1];
                    err_d  = 1'b0;
                end else begin
                    out_d  = '0;
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                    zero_d = 1'b1;
                    neg_d  = 1'b0;
                    err_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            out_hi_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_hi_q    <= out_hi_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ready     = ready;
    assign bus.out       = out_q;
    assign bus.out_hi    = out_hi_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, back-pressure, streaming,
// reset during multiply, MUL_EN=0 instance, and randomized ops with stalls.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct {
        logic [7:0] out;
        logic [7:0] hi;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
        logic       err;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq_if #(.WIDTH(W)) bus2 ();

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Reference: result and flags computed from the arithmetic meaning of each op.
    function automatic res_t model(input logic [3:0] op, input logic [7:0] a8,
                                   input logic [7:0] b8, input bit mul_en);
        res_t r;
        int unsigned a, b, p, amt;
        int sa, sb, s;
        a = a8; b = b8;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        amt = b % W;
        r.out = '0; r.hi = '0; r.cout = 1'b0; r.ovf = 1'b0; r.err = 1'b0;
        case (op)
            4'hF: begin
                p = a + b; r.out = 8'(p); r.cout = (p >= 256);
                s = sa + sb; r.ovf = (s > 127) || (s < -128);
            end
            4'hE: begin
                p = a + 256 - b; r.out = 8'(p); r.cout = (a >= b);
                s = sa - sb; r.ovf = (s > 127) || (s < -128);
            end
            4'h7: r.out = a8 & b8;
            4'h6: r.out = a8 | b8;
            4'h4: r.out = ~a8;
            4'h5: r.out = a8 ^ b8;
            4'h8: begin
                p = a << amt; r.out = 8'(p);
                r.cout = (amt != 0) ? (((a >> (W - amt)) & 1) != 0) : 1'b0;
            end
            4'h9: r.out = 8'(a >> amt);
            4'hC: begin
                if (mul_en) begin
                    p = a * b; r.out = 8'(p); r.hi = 8'(p >> 8);
                end else begin
                    r.err = 1'b1;
                end
            end
            default: r.err = 1'b1;
        endcase
        r.zero = (r.out == 0) && (r.hi == 0);
        r.neg  = r.out[7];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string t, input res_t e);
        check({t, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({t, "_out"},   32'(bus.out),       32'(e.out));
        check({t, "_hi"},    32'(bus.out_hi),    32'(e.hi));
        check({t, "_cout"},  32'(bus.cout),      32'(e.cout));
        check({t, "_ovf"},   32'(bus.ovf),       32'(e.ovf));
        check({t, "_zero"},  32'(bus.zero),      32'(e.zero));
        check({t, "_neg"},   32'(bus.neg),       32'(e.neg));
        check({t, "_err"},   32'(bus.err),       32'(e.err));
    endtask

    // Issue one op from IDLE and wait (bounded) for its result; returns at
    // negedge+1 with the result held, out_ready=1 and en=0.
    task automatic exec_op(input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, output res_t e);
        int k, low;
        string t;
        t = $sformatf("op%h_%h_%h", op, a, b);
        e = model(op, a, b, 1'b1);
        @(negedge clk);
        bus.en = 1'b1; bus.opcode = op; bus.a = a; bus.b = b; bus.out_ready = 1'b1;
        #1 check({t, "_ready_idle"}, 32'(bus.ready), 32'd1);
        @(negedge clk);
        bus.en = 1'b0;
        bus.opcode = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
        #1;
        k = 0; low = 0;
        while (bus.out_valid !== 1'b1 && k < 64) begin
            if (bus.ready === 1'b0) low++;
            @(negedge clk);
            #1;
            k++;
        end
        check({t, "_latency"}, 32'(k), (op == 4'hC) ? 32'(W) : 32'd0);
        if (op == 4'hC) check({t, "_ready_low"}, 32'(low), 32'(W));
        check_res(t, e);
    endtask

    task automatic retire(input string t);
        @(negedge clk);
        #1;
        check({t, "_retired_valid"}, 32'(bus.out_valid), 32'd0);
        check({t, "_retired_ready"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        res_t e, e2;
        logic [3:0] ops [10];
        logic [7:0] ra, rb;
        int stall;

        ops[0] = 4'hF; ops[1] = 4'hE; ops[2] = 4'h7; ops[3] = 4'h6; ops[4] = 4'h4;
        ops[5] = 4'h5; ops[6] = 4'h8; ops[7] = 4'h9; ops[8] = 4'hC; ops[9] = 4'h3;

        rst = 1'b1;
        bus.en = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        bus2.en = 1'b0; bus2.opcode = '0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out",   32'(bus.out),       32'd0);
        check("rst_hi",    32'(bus.out_hi),    32'd0);
        check("rst_flags", 32'({bus.cout, bus.ovf, bus.zero, bus.neg, bus.err}), 32'd0);
        check("rst_ready", 32'(bus.ready),     32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with literal expectations alongside the model.
        exec_op(4'hF, 8'hff, 8'hff, e);
        check("add_ff_ff_lit", 32'({bus.out, bus.cout, bus.ovf, bus.neg, bus.zero}),
              32'({8'hfe, 1'b1, 1'b0, 1'b1, 1'b0}));
        retire("add");
        exec_op(4'hE, 8'h00, 8'h01, e);
        check("sub_00_01_lit", 32'({bus.out, bus.cout, bus.ovf, bus.neg}),
              32'({8'hff, 1'b0, 1'b0, 1'b1}));
        retire("sub1");
        exec_op(4'hE, 8'h80, 8'h01, e);
        check("sub_80_01_lit", 32'({bus.out, bus.ovf}), 32'({8'h7f, 1'b1}));
        retire("sub2");
        exec_op(4'h6, 8'hcc, 8'h33, e);
        check("or_lit", 32'(bus.out), 32'h0ff);
        retire("or");
        exec_op(4'h7, 8'hcc, 8'h33, e);
        check("and_lit", 32'({bus.out, bus.zero}), 32'({8'h00, 1'b1}));
        retire("and");
        exec_op(4'h4, 8'haa, 8'h00, e);
        check("not_lit", 32'(bus.out), 32'h055);
        retire("not");
        exec_op(4'h8, 8'h81, 8'h09, e);
        check("shl_lit", 32'({bus.out, bus.cout}), 32'({8'h02, 1'b1}));
        retire("shl");
        exec_op(4'h9, 8'hf0, 8'h08, e);
        check("shr_amt0_lit", 32'({bus.out, bus.cout}), 32'({8'hf0, 1'b0}));
        retire("shr");
        exec_op(4'hC, 8'hff, 8'hff, e);
        check("mul_lit", 32'({bus.out_hi, bus.out}), 32'h0fe01);
        retire("mul");
        exec_op(4'h3, 8'h12, 8'h34, e);
        check("illegal_lit", 32'({bus.err, bus.zero, bus.out}), 32'({1'b1, 1'b1, 8'h00}));
        retire("illegal");

        // MUL_EN=0 instance: multiply opcode is illegal.
        @(negedge clk);
        bus2.en = 1'b1; bus2.opcode = 4'hC; bus2.a = 8'hff; bus2.b = 8'hff;
        @(negedge clk);
        bus2.en = 1'b0;
        #1;
        check("nomul_valid", 32'(bus2.out_valid), 32'd1);
        check("nomul_err",   32'({bus2.err, bus2.zero, bus2.out, bus2.out_hi}),
              32'({1'b1, 1'b1, 8'h00, 8'h00}));

        // Back-pressure with a second request pending, then streaming adds.
        exec_op(4'hF, 8'h5a, 8'h27, e);
        bus.out_ready = 1'b0;
        bus.en = 1'b1; bus.opcode = 4'hE; bus.a = 8'h10; bus.b = 8'h20;
        e2 = model(4'hE, 8'h10, 8'h20, 1'b1);
        #1 check("bp_ready0", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_hold%0d_ready", i), 32'(bus.ready), 32'd0);
            check($sformatf("bp_hold%0d_out", i),
                  32'({bus.out_valid, bus.out, bus.cout, bus.ovf, bus.zero, bus.neg}),
                  32'({1'b1, e.out, e.cout, e.ovf, e.zero, e.neg}));
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        #1;
        check_res("bp_next", e2);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            bus.opcode = 4'hF; bus.a = ra; bus.b = rb;
            e = model(4'hF, ra, rb, 1'b1);
            @(negedge clk);
            #1;
            check_res($sformatf("stream%0d", i), e);
        end
        bus.en = 1'b0;
        retire("stream");

        // Reset during the third EXEC cycle of a multiply.
        exec_op(4'h6, 8'h81, 8'h42, e);
        @(negedge clk);
        bus.en = 1'b1; bus.opcode = 4'hC; bus.a = 8'hff; bus.b = 8'hff;
        @(negedge clk);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("mid_mul_busy", 32'(bus.ready), 32'd0);
        #1 rst = 1'b1;
        #1;
        check("rstmul_out",   32'({bus.out, bus.out_hi}), 32'd0);
        check("rstmul_flags", 32'({bus.out_valid, bus.cout, bus.ovf, bus.zero, bus.neg, bus.err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rstmul_ready", 32'(bus.ready), 32'd1);
        exec_op(4'hC, 8'h0d, 8'h0b, e);
        retire("after_rst");

        // Randomized ops with random consumer stalls.
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if (i % 5 == 4) rb = 8'($urandom_range(0, 15));
            exec_op(ops[$urandom_range(0, 9)], ra, rb, e);
            stall = $urandom_range(0, 2);
            bus.out_ready = (stall == 0);
            for (int j = 0; j < stall; j++) begin
                @(negedge clk);
                #1 check($sformatf("rnd%0d_stall%0d", i, j),
                         32'({bus.out_valid, bus.out, bus.out_hi}), 32'({1'b1, e.out, e.hi}));
            end
            bus.out_ready = 1'b1;
            retire($sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
